// File: rtl/dense_layer_compute_mlane.sv
// Multi-lane dense layer engine: LANES output channels accumulate in parallel, one input
// element per cycle, and results stream out one channel at a time over valid/ready.

module dense_layer_compute_mlane_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              mac_en,
  input  logic [ACC_W-1:0]  bias,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           prod_ext;
  logic [ACC_W-1:0]           acc_d, acc_q;

  assign prod     = $signed(x) * $signed(w);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (load)        acc_d = bias;
    else if (mac_en) acc_d = acc_q + prod_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

module dense_layer_compute_mlane #(
  parameter int MAX_IN  = 256,
  parameter int MAX_OUT = 64,
  parameter int LANES   = 4,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  localparam int IN_W   = $clog2(MAX_IN+1),
  localparam int OUT_W  = $clog2(MAX_OUT+1),
  localparam int TA_W   = $clog2(MAX_IN),
  localparam int WA_W   = $clog2(MAX_IN*MAX_OUT/LANES),
  localparam int BA_W   = (MAX_OUT/LANES > 1) ? $clog2(MAX_OUT/LANES) : 1,
  localparam int CH_W   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    relu_en,
  input  logic [IN_W-1:0]         input_size,
  input  logic [OUT_W-1:0]        output_size,
  output logic [TA_W-1:0]         tensor_ram_addr,
  output logic                    tensor_ram_re,
  input  logic [DATA_W-1:0]       tensor_ram_dout,
  output logic [WA_W-1:0]         weight_rom_addr,
  output logic                    weight_rom_re,
  input  logic [LANES*DATA_W-1:0] weight_rom_dout,
  output logic [BA_W-1:0]         bias_rom_addr,
  output logic                    bias_rom_re,
  input  logic [LANES*ACC_W-1:0]  bias_rom_dout,
  output logic [ACC_W-1:0]        out_data,
  output logic [CH_W-1:0]         out_channel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);
  localparam int L_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CB_W = OUT_W + 1;

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, EMIT, DONE} state_t;

  state_t            state_d, state_q;
  logic [IN_W-1:0]   n_d, n_q, k_d, k_q;
  logic [OUT_W-1:0]  m_d, m_q;
  logic              relu_d, relu_q;
  logic [BA_W-1:0]   g_d, g_q;
  logic [L_W-1:0]    l_d, l_q;
  logic [WA_W-1:0]   wbase_d, wbase_q;
  logic [CB_W-1:0]   base_ch_d, base_ch_q;

  logic [LANES-1:0][ACC_W-1:0] acc;
  logic [ACC_W-1:0]            acc_sel;
  logic [CB_W-1:0]             ch_full;
  logic                        lane_last, group_last, lane_load, lane_mac;

  assign ch_full    = base_ch_q + CB_W'(l_q);
  assign lane_last  = (l_q == L_W'(LANES-1)) || (ch_full == CB_W'(m_q) - CB_W'(1));
  assign group_last = (base_ch_q + CB_W'(LANES)) >= CB_W'(m_q);
  assign lane_load  = (state_q == MAC) && (k_q == '0);
  // Memory data lags the address by one cycle, so lane MACs trail the reads and DRAIN finishes the last one.
  assign lane_mac   = ((state_q == MAC) && (k_q != '0)) || (state_q == DRAIN);

  genvar gl;
  generate
    for (gl = 0; gl < LANES; gl++) begin : g_lane
      dense_layer_compute_mlane_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
        .clk    (clk),
        .reset  (reset),
        .load   (lane_load),
        .mac_en (lane_mac),
        .bias   (bias_rom_dout[gl*ACC_W +: ACC_W]),
        .x      (tensor_ram_dout),
        .w      (weight_rom_dout[gl*DATA_W +: DATA_W]),
        .acc    (acc[gl])
      );
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    m_d       = m_q;
    relu_d    = relu_q;
    g_d       = g_q;
    k_d       = k_q;
    l_d       = l_q;
    wbase_d   = wbase_q;
    base_ch_d = base_ch_q;
    case (state_q)
      IDLE: if (start) begin
        n_d       = input_size;
        m_d       = output_size;
        relu_d    = relu_en;
        g_d       = '0;
        wbase_d   = '0;
        base_ch_d = '0;
        state_d   = (input_size == '0 || output_size == '0) ? DONE : BIAS;
      end
      BIAS: begin
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        k_d = k_q + IN_W'(1);
        if (k_q == n_q - IN_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        l_d     = '0;
        state_d = EMIT;
      end
      EMIT: if (out_ready) begin
        if (!lane_last) l_d = l_q + L_W'(1);
        else if (group_last) state_d = DONE;
        else begin
          g_d       = g_q + BA_W'(1);
          wbase_d   = wbase_q + WA_W'(n_q);
          base_ch_d = base_ch_q + CB_W'(LANES);
          state_d   = BIAS;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      m_q       <= '0;
      relu_q    <= 1'b0;
      g_q       <= '0;
      k_q       <= '0;
      l_q       <= '0;
      wbase_q   <= '0;
      base_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      m_q       <= m_d;
      relu_q    <= relu_d;
      g_q       <= g_d;
      k_q       <= k_d;
      l_q       <= l_d;
      wbase_q   <= wbase_d;
      base_ch_q <= base_ch_d;
    end
  end

  assign acc_sel = acc[l_q];

  // Outputs decode directly from registered state, so they are zero in IDLE and right after reset.
  always_comb begin
    busy            = (state_q != IDLE);
    done            = (state_q == DONE);
    bias_rom_re     = (state_q == BIAS);
    tensor_ram_re   = (state_q == MAC);
    weight_rom_re   = (state_q == MAC);
    out_valid       = (state_q == EMIT);
    bias_rom_addr   = bias_rom_re   ? g_q : '0;
    tensor_ram_addr = tensor_ram_re ? TA_W'(k_q) : '0;
    weight_rom_addr = weight_rom_re ? wbase_q + WA_W'(k_q) : '0;
    out_channel     = out_valid ? CH_W'(ch_full) : '0;
    out_data        = '0;
    if (out_valid) out_data = (relu_q && acc_sel[ACC_W-1]) ? '0 : acc_sel;
  end
endmodule

// File: tb/tb_dense_layer_compute_mlane.sv
// Scoreboarded random/directed bench for the multi-lane dense engine with behavioural memories.

module tb_dense_layer_compute_mlane;
  localparam int MAX_IN = 256, MAX_OUT = 64, LANES = 4, DATA_W = 8, ACC_W = 32;
  localparam int IN_W = $clog2(MAX_IN+1), OUT_W = $clog2(MAX_OUT+1), TA_W = $clog2(MAX_IN);
  localparam int WA_W = $clog2(MAX_IN*MAX_OUT/LANES), BA_W = $clog2(MAX_OUT/LANES), CH_W = $clog2(MAX_OUT);

  logic clk, reset, start, relu_en, out_ready;
  logic [IN_W-1:0] input_size;
  logic [OUT_W-1:0] output_size;
  logic [TA_W-1:0] tensor_ram_addr;
  logic tensor_ram_re, weight_rom_re, bias_rom_re, out_valid, busy, done;
  logic [DATA_W-1:0] tensor_ram_dout;
  logic [WA_W-1:0] weight_rom_addr;
  logic [LANES*DATA_W-1:0] weight_rom_dout;
  logic [BA_W-1:0] bias_rom_addr;
  logic [LANES*ACC_W-1:0] bias_rom_dout;
  logic [ACC_W-1:0] out_data;
  logic [CH_W-1:0] out_channel;

  dense_layer_compute_mlane #(.MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT), .LANES(LANES),
    .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .input_size(input_size), .output_size(output_size),
    .tensor_ram_addr(tensor_ram_addr), .tensor_ram_re(tensor_ram_re), .tensor_ram_dout(tensor_ram_dout),
    .weight_rom_addr(weight_rom_addr), .weight_rom_re(weight_rom_re), .weight_rom_dout(weight_rom_dout),
    .bias_rom_addr(bias_rom_addr), .bias_rom_re(bias_rom_re), .bias_rom_dout(bias_rom_dout),
    .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference storage: logical tensors plus the packed ROM images the DUT reads.
  logic signed [7:0]       xm [MAX_IN];
  logic signed [7:0]       wm [MAX_OUT][MAX_IN];
  int                      bm [MAX_OUT];
  logic [LANES*DATA_W-1:0] wrom [4096];
  logic [LANES*ACC_W-1:0]  brom [16];

  always @(posedge clk) begin
    if (tensor_ram_re) tensor_ram_dout <= xm[tensor_ram_addr];
    if (weight_rom_re) weight_rom_dout <= wrom[weight_rom_addr];
    if (bias_rom_re)   bias_rom_dout   <= brom[bias_rom_addr];
  end

  typedef struct { int ch; int data; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int done_cnt, re_cnt, valid_cnt, wre_cnt, wmax;
  int ready_mode = 0;
  int rcnt = 0;
  bit held = 0;
  logic [ACC_W-1:0] hd;
  logic [CH_W-1:0]  hc;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Downstream ready pattern: 0 always ready, 1 random, 2 repeating 1,0,0,1.
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       begin out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3); rcnt++; end
        default: out_ready = 1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted output and checks stability while stalled.
  always @(negedge clk) begin
    if (reset) held = 0;
    else begin
      if (done) done_cnt++;
      if (tensor_ram_re || weight_rom_re || bias_rom_re) re_cnt++;
      if (weight_rom_re) begin
        wre_cnt++;
        if (int'(weight_rom_addr) > wmax) wmax = int'(weight_rom_addr);
      end
      if (out_valid) begin
        valid_cnt++;
        if (held) begin
          check("stall_data", int'(out_data), int'(hd));
          check("stall_ch", int'(out_channel), int'(hc));
        end
        if (out_ready) begin
          held = 0;
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_out: got ch %0d data %0d, none expected", out_channel, $signed(out_data));
          end else begin
            exp_t e;
            e = q.pop_front();
            check("out_ch", int'(out_channel), e.ch);
            check("out_data", int'(out_data), e.data);
          end
        end else begin
          held = 1; hd = out_data; hc = out_channel;
        end
      end else held = 0;
    end
  end

  task automatic load_roms(input int n, input int m, input bit relu);
    int acc;
    exp_t e;
    for (int g = 0; g < 16; g++) begin
      for (int l = 0; l < LANES; l++) begin
        int ch = g*LANES + l;
        brom[g][l*ACC_W +: ACC_W] = (ch < m) ? bm[ch] : $urandom;
        for (int i = 0; i < n; i++)
          if (g*n + i < 4096)
            wrom[g*n+i][l*DATA_W +: DATA_W] = (ch < m) ? wm[ch][i] : 8'($urandom);
      end
    end
    if (n > 0) begin
      for (int o = 0; o < m; o++) begin
        acc = bm[o];
        for (int i = 0; i < n; i++) acc += int'(xm[i]) * int'(wm[o][i]);
        if (relu && acc < 0) acc = 0;
        e.ch = o; e.data = acc;
        q.push_back(e);
      end
    end
  endtask

  task automatic randomize_data(input int n, input int m);
    for (int i = 0; i < n; i++) xm[i] = 8'($urandom);
    for (int o = 0; o < m; o++) begin
      bm[o] = int'($urandom_range(0, 2000)) - 1000;
      for (int i = 0; i < n; i++) wm[o][i] = 8'($urandom);
    end
  endtask

  task automatic pulse_start(input int n, input int m, input bit relu);
    @(negedge clk);
    start = 1; input_size = IN_W'(n); output_size = OUT_W'(m); relu_en = relu;
    @(negedge clk);
    start = 0; input_size = IN_W'($urandom); output_size = OUT_W'($urandom); relu_en = 1'($urandom);
  endtask

  // Runs one operation; lat is cycles from BIAS entry to first out_valid (-1 if none).
  task automatic run_op(input string tag, input int n, input int m, input bit relu, input bit stray,
                        output int lat);
    int cyc;
    done_cnt = 0; re_cnt = 0; valid_cnt = 0; wre_cnt = 0; wmax = -1;
    load_roms(n, m, relu);
    pulse_start(n, m, relu);
    lat = -1;
    if (n > 0 && m > 0) begin
      cyc = 0;
      while (!out_valid && cyc < 2000) begin @(negedge clk); cyc++; end
      if (out_valid) lat = cyc;
      if (stray) pulse_start(1, 1, 0);
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_queue_left"}, q.size(), 0);
    q.delete();
  endtask

  int lat;

  initial begin
    reset = 1; start = 0; relu_en = 0; input_size = '0; output_size = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_outs", int'({out_valid, done, tensor_ram_re, weight_rom_re, bias_rom_re}), 0);
    check("rst_data", int'(out_data), 0);
    reset = 0;

    // Directed: every lane gets sum(x)*(o+1) plus its bias.
    for (int i = 0; i < 4; i++) xm[i] = 8'(i + 1);
    for (int o = 0; o < 4; o++) for (int i = 0; i < 4; i++) wm[o][i] = 8'(o + 1);
    bm[0] = 10; bm[1] = 0; bm[2] = -5; bm[3] = 0;
    run_op("basic", 4, 4, 0, 0, lat);
    check("basic_latency", lat, 6);
    check("basic_outputs", valid_cnt, 4);

    // Partial final group.
    randomize_data(3, 6);
    run_op("partial", 3, 6, 0, 0, lat);
    check("partial_latency", lat, 5);
    check("partial_wmax", wmax, 5);
    check("partial_wreads", wre_cnt, 6);
    check("partial_outputs", valid_cnt, 6);

    // ReLU corner: most negative product.
    xm[0] = -8'sd128; wm[0][0] = 8'sd127; bm[0] = 0;
    run_op("relu_on", 1, 1, 1, 0, lat);
    run_op("relu_off", 1, 1, 0, 0, lat);

    // Back-pressure pattern.
    ready_mode = 2; rcnt = 0;
    randomize_data(5, 7);
    run_op("stall", 5, 7, 1, 0, lat);
    ready_mode = 0;

    // Empty operations: no reads, no outputs, done on the next cycle.
    for (int z = 0; z < 2; z++) begin
      done_cnt = 0; re_cnt = 0; valid_cnt = 0;
      pulse_start(z == 0 ? 0 : 3, z == 0 ? 5 : 0, 0);
      check("empty_done_now", int'(done), 1);
      repeat (3) @(negedge clk);
      check("empty_done_cnt", done_cnt, 1);
      check("empty_reads", re_cnt, 0);
      check("empty_valid", valid_cnt, 0);
    end

    // Reset during the second group's MAC phase.
    randomize_data(5, 8);
    load_roms(5, 8, 0);
    done_cnt = 0;
    pulse_start(5, 8, 0);
    begin
      int cyc = 0;
      while (!(weight_rom_re && weight_rom_addr >= 5) && cyc < 2000) begin @(negedge clk); cyc++; end
      check("abort_reached_g1", int'(weight_rom_re && weight_rom_addr >= 5), 1);
    end
    reset = 1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_outs", int'({out_valid, done, tensor_ram_re, weight_rom_re, bias_rom_re}), 0);
    check("abort_data", int'(out_data), 0);
    check("abort_ch", int'(out_channel), 0);
    reset = 0;
    q.delete();
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    randomize_data(5, 8);
    run_op("after_abort", 5, 8, 0, 0, lat);

    // Random operations under random back-pressure, with a stray start while busy.
    ready_mode = 1;
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(1, 24);
      int m = $urandom_range(1, 13);
      randomize_data(n, m);
      run_op("rand", n, m, 1'($urandom_range(0, 1)), t[0], lat);
    end
    ready_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
